// File: rtl/ncc_window_loader.sv
// ncc_window_loader
// Ping-pong search-window store in front of the NCC correlator. The PCI pixel
// stream fills one bank (ROWS row memories, COLS deep) in row-major order while
// the correlator reads whole columns out of the other bank. Banks are handed to
// the consumer strictly in fill order.
module ncc_window_loader #(
  parameter  int ROWS  = 16,
  parameter  int COLS  = 80,
  parameter  int PIX_W = 8,
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  // pixel stream in
  input  logic                    in_valid,
  input  logic [PIX_W-1:0]        in_data,
  output logic                    in_ready,
  input  logic                    frame_abort,
  // window handshake
  output logic                    win_valid,
  output logic                    win_bank,
  // column read port
  input  logic [CW-1:0]           rd_col,
  input  logic                    rd_en,
  output logic [ROWS*PIX_W-1:0]   rd_column,
  output logic                    rd_valid,
  // release
  input  logic                    win_release,
  output logic                    release_err
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} bank_st_e;

  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW:0]   COL_LIM  = (CW + 1)'(COLS);

  // Per-bank full/empty state
  bank_st_e r_st     [2];
  bank_st_e w_st_nxt [2];
  logic [1:0] w_full;

  // Write side
  logic          r_wr_bank;
  logic [RW-1:0] r_wr_row;
  logic [CW-1:0] r_wr_col;
  logic          w_in_ready;
  logic          w_xfer;
  logic          w_col_last;
  logic          w_last;

  // Read side
  logic          r_rd_bank;
  logic          w_win_valid;
  logic          w_rel;
  logic          w_rd_ok;
  logic          r_rd_valid;
  logic          r_release_err;
  logic [ROWS-1:0][PIX_W-1:0] r_rd_column;
  logic [PIX_W-1:0]           w_rd_pix [2][ROWS];

  // A transfer is the handshake; the bank's final pixel is the one that
  // sits at the last row and last column.
  assign w_xfer     = in_valid && w_in_ready;
  assign w_col_last = (r_wr_col == COL_LAST);
  assign w_last     = w_xfer && w_col_last && (r_wr_row == ROW_LAST);
  // A release only counts when there is a full bank to give back.
  assign w_rel      = win_release && w_win_valid;
  // Columns past the end of the window read nothing meaningful.
  assign w_rd_ok    = ({1'b0, rd_col} < COL_LIM);

  // Bank state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st[0] <= S_EMPTY;
      r_st[1] <= S_EMPTY;
    end else begin
      r_st[0] <= w_st_nxt[0];
      r_st[1] <= w_st_nxt[1];
    end
  end

  // Bank next state: fills on the final pixel, empties when released as the read bank
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_st_nxt[b] = r_st[b];
      case (r_st[b])
        S_EMPTY: if (w_last && (r_wr_bank == 1'(b))) w_st_nxt[b] = S_FULL;
        S_FULL:  if (w_rel && (r_rd_bank == 1'(b)))  w_st_nxt[b] = S_EMPTY;
        default: w_st_nxt[b] = S_EMPTY;
      endcase
    end
  end

  // Bank-state outputs: flow control towards the stream and the consumer
  always_comb begin
    w_full[0]   = (r_st[0] == S_FULL);
    w_full[1]   = (r_st[1] == S_FULL);
    w_in_ready  = !w_full[r_wr_bank] && !frame_abort;
    w_win_valid = w_full[r_rd_bank];
  end

  // Row-major write pointer; an abort restarts the frame in the same bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_bank <= 1'b0;
      r_wr_row  <= '0;
      r_wr_col  <= '0;
    end else if (frame_abort) begin
      r_wr_row  <= '0;
      r_wr_col  <= '0;
    end else if (w_xfer) begin
      if (w_col_last) begin
        r_wr_col <= '0;
        if (r_wr_row == ROW_LAST) begin
          r_wr_row  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_row <= r_wr_row + 1'b1;
        end
      end else begin
        r_wr_col <= r_wr_col + 1'b1;
      end
    end
  end

  // Read bank pointer and sticky error for releases with nothing to release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_bank     <= 1'b0;
      r_release_err <= 1'b0;
    end else begin
      if (w_rel) r_rd_bank <= ~r_rd_bank;
      if (win_release && !w_win_valid) r_release_err <= 1'b1;
    end
  end

  // One row memory per window row per bank, so a full column is one access
  for (genvar gb = 0; gb < 2; gb++) begin : g_bank
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
      logic [PIX_W-1:0] r_mem [COLS];
      logic             w_we;

      assign w_we = w_xfer && (r_wr_bank == 1'(gb)) && (r_wr_row == RW'(gr));

      // RAM write port; left unreset so it maps onto memory primitives
      always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wr_col] <= in_data;
      end

      assign w_rd_pix[gb][gr] = w_rd_ok ? r_mem[rd_col] : '0;
    end
  end

  // Registered column read; data holds between strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid  <= 1'b0;
      r_rd_column <= '0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        for (int r = 0; r < ROWS; r++) r_rd_column[r] <= w_rd_pix[r_rd_bank][r];
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign win_valid   = w_win_valid;
  assign win_bank    = r_rd_bank;
  assign rd_column   = r_rd_column;
  assign rd_valid    = r_rd_valid;
  assign release_err = r_release_err;

endmodule

// File: tb/tb_ncc_window_loader.sv
// Bench for ncc_window_loader: a behavioural model of the ping-pong store
// predicts every column read; expected columns are queued when rd_en is driven
// and popped when rd_valid is due. Scenario tasks add point checks.
module tb_ncc_window_loader;
  localparam int ROWS  = 16;
  localparam int COLS  = 80;
  localparam int PIX_W = 8;
  localparam int CW    = $clog2(COLS);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, frame_abort = 1'b0, rd_en = 1'b0, win_release = 1'b0;
  logic [PIX_W-1:0] in_data = '0;
  logic [CW-1:0]    rd_col = '0;
  logic in_ready, win_valid, win_bank, rd_valid, release_err;
  logic [ROWS*PIX_W-1:0] rd_column;

  ncc_window_loader #(.ROWS(ROWS), .COLS(COLS), .PIX_W(PIX_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .frame_abort(frame_abort), .win_valid(win_valid), .win_bank(win_bank),
    .rd_col(rd_col), .rd_en(rd_en), .rd_column(rd_column), .rd_valid(rd_valid),
    .win_release(win_release), .release_err(release_err));

  always #5 clk = ~clk;

  typedef struct { logic dc; logic [ROWS*PIX_W-1:0] col; } sb_t;
  sb_t sb[$];
  int vectors = 0, errors = 0;

  // reference model
  logic [PIX_W-1:0] m_mem [2][ROWS][COLS];
  logic m_full [2];
  logic m_wb, m_rb, m_rel_err, m_rdv, m_last_known;
  int   m_row, m_col;
  logic [ROWS*PIX_W-1:0] m_last;

  function automatic logic m_ready();
    return !m_full[m_wb] && !frame_abort;
  endfunction

  // one clock: predict reads, advance the model across the edge
  task automatic step();
    logic rdy, rel;
    sb_t it;
    rdy = m_ready();
    rel = win_release && m_full[m_rb];
    if (rd_en) begin
      it.dc  = !m_full[m_rb] || (int'(rd_col) >= COLS);
      it.col = '0;
      if (!it.dc) for (int r = 0; r < ROWS; r++) it.col[r*PIX_W +: PIX_W] = m_mem[m_rb][r][rd_col];
      sb.push_back(it);
    end
    @(posedge clk);
    m_rdv = rd_en;
    if (win_release && !m_full[m_rb]) m_rel_err = 1'b1;
    if (frame_abort) begin
      m_row = 0; m_col = 0;
    end else if (in_valid && rdy) begin
      m_mem[m_wb][m_row][m_col] = in_data;
      if (m_col == COLS-1) begin
        m_col = 0;
        if (m_row == ROWS-1) begin m_row = 0; m_full[m_wb] = 1'b1; m_wb = !m_wb; end
        else m_row++;
      end else m_col++;
    end
    if (rel) begin m_full[m_rb] = 1'b0; m_rb = !m_rb; end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 0; frame_abort = 0; rd_en = 0; win_release = 0;
    m_full = '{1'b0, 1'b0}; m_wb = 0; m_rb = 0; m_row = 0; m_col = 0;
    m_rel_err = 0; m_rdv = 0; m_last = '0; m_last_known = 1; sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // scoreboard pop and rd_valid / hold checks, sampled mid-cycle
  always @(negedge clk) begin : mon
    sb_t it;
    if (!rst) begin
      vectors++;
      if (rd_valid !== m_rdv) begin errors++; $display("FAIL rd_valid: got %b want %b", rd_valid, m_rdv); end
      if (m_rdv) begin
        if (sb.size() == 0) begin
          vectors++; errors++; $display("FAIL sb_empty: got read with no expectation");
        end else begin
          it = sb.pop_front();
          if (!it.dc) begin
            vectors++;
            if (rd_column !== it.col) begin errors++; $display("FAIL rd_column: got %h want %h", rd_column, it.col); end
            m_last = it.col; m_last_known = 1;
          end else m_last_known = 0;
        end
      end else if (m_last_known) begin
        vectors++;
        if (rd_column !== m_last) begin errors++; $display("FAIL rd_hold: got %h want %h", rd_column, m_last); end
      end
    end
  end

  task automatic read_col(input int c);
    rd_col = CW'(c); rd_en = 1; step(); rd_en = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (win_valid !== 1'b0)   begin errors++; $display("FAIL reset_win_valid: got %b want 0", win_valid); end
    vectors++; if (win_bank !== 1'b0)    begin errors++; $display("FAIL reset_win_bank: got %b want 0", win_bank); end
    vectors++; if (rd_valid !== 1'b0)    begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    vectors++; if (rd_column !== '0)     begin errors++; $display("FAIL reset_rd_column: got %h want 0", rd_column); end
    vectors++; if (release_err !== 1'b0) begin errors++; $display("FAIL reset_release_err: got %b want 0", release_err); end
    vectors++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_release_err();
    win_release = 1; step(); win_release = 0;
    vectors++; if (release_err !== 1'b1) begin errors++; $display("FAIL relerr_set: got %b want 1", release_err); end
    vectors++; if (win_valid !== 1'b0)   begin errors++; $display("FAIL relerr_win_valid: got %b want 0", win_valid); end
    vectors++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL relerr_in_ready: got %b want 1", in_ready); end
    repeat (3) step();
    vectors++; if (release_err !== 1'b1) begin errors++; $display("FAIL relerr_sticky: got %b want 1", release_err); end
  endtask

  task automatic test_fill();
    in_valid = 1;
    for (int i = 0; i < ROWS*COLS; i++) begin
      in_data = 8'(m_row*COLS + m_col);
      step();
      if (i == ROWS*COLS-2) begin
        vectors++; if (win_valid !== 1'b0) begin errors++; $display("FAIL fill_early_valid: got %b want 0", win_valid); end
      end
    end
    in_valid = 0;
    vectors++; if (win_valid !== 1'b1) begin errors++; $display("FAIL fill_win_valid: got %b want 1", win_valid); end
    vectors++; if (win_bank !== 1'b0)  begin errors++; $display("FAIL fill_win_bank: got %b want 0", win_bank); end
    vectors++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL fill_in_ready: got %b want 1", in_ready); end
    vectors++; if (release_err !== m_rel_err) begin errors++; $display("FAIL fill_relerr: got %b want %b", release_err, m_rel_err); end
    read_col(5);
    vectors++; if (rd_column[3*PIX_W +: PIX_W] !== 8'(3*80+5)) begin errors++; $display("FAIL fill_col5_row3: got %h want %h", rd_column[3*PIX_W +: PIX_W], 8'(3*80+5)); end
    read_col(0); read_col(79); read_col(100); step(); step();
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1;
    for (int i = 0; i < 2*ROWS*COLS; i++) begin
      in_data = (i < ROWS*COLS) ? 8'(i) : 8'(i*3 + 7);
      step();
    end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b want 0", in_ready); end
    in_data = 8'h55;
    repeat (3) step();
    vectors++; if (in_ready !== m_ready()) begin errors++; $display("FAIL bp_hold: got %b want %b", in_ready, m_ready()); end
    vectors++; if (win_bank !== 1'b0) begin errors++; $display("FAIL bp_bank_before: got %b want 0", win_bank); end
    win_release = 1; step(); win_release = 0;
    vectors++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_resume: got %b want 1", in_ready); end
    vectors++; if (win_bank !== 1'b1)  begin errors++; $display("FAIL bp_win_bank: got %b want 1", win_bank); end
    vectors++; if (win_valid !== 1'b1) begin errors++; $display("FAIL bp_win_valid: got %b want 1", win_valid); end
    step(); in_valid = 0;
    read_col(0);
    vectors++; if (rd_column[2*PIX_W +: PIX_W] !== 8'((1280+160)*3+7)) begin errors++; $display("FAIL bp_col0_row2: got %h want %h", rd_column[2*PIX_W +: PIX_W], 8'((1280+160)*3+7)); end
    read_col(79); step();
  endtask

  task automatic test_abort();
    do_reset();
    in_valid = 1;
    for (int i = 0; i < 700; i++) begin in_data = 8'(i ^ 8'h3C); step(); end
    frame_abort = 1; in_data = 8'h11; #1;
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready: got %b want 0", in_ready); end
    step(); frame_abort = 0;
    in_data = 8'hAA;
    for (int i = 0; i < ROWS*COLS; i++) step();
    in_valid = 0;
    vectors++; if (win_valid !== 1'b1) begin errors++; $display("FAIL abort_win_valid: got %b want 1", win_valid); end
    vectors++; if (win_bank !== 1'b0)  begin errors++; $display("FAIL abort_win_bank: got %b want 0", win_bank); end
    rd_en = 1;
    for (int c = 0; c < COLS; c++) begin rd_col = CW'(c); step(); end
    rd_en = 0;
    vectors++; if (rd_column !== {ROWS{8'hAA}}) begin errors++; $display("FAIL abort_col79: got %h want all aa", rd_column); end
    step();
  endtask

  task automatic test_simul();
    in_valid = 1;
    for (int i = 0; i < ROWS*COLS; i++) begin
      in_data = 8'(i*5 + 1);
      win_release = (i == ROWS*COLS-1);
      if (i == ROWS*COLS-1) begin
        vectors++; if (win_bank !== 1'b0) begin errors++; $display("FAIL simul_bank_before: got %b want 0", win_bank); end
      end
      step();
    end
    win_release = 0; in_valid = 0;
    vectors++; if (win_valid !== 1'b1) begin errors++; $display("FAIL simul_win_valid: got %b want 1", win_valid); end
    vectors++; if (win_bank !== 1'b1)  begin errors++; $display("FAIL simul_win_bank: got %b want 1", win_bank); end
    vectors++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL simul_in_ready: got %b want 1", in_ready); end
    read_col(3);
    vectors++; if (rd_column[1*PIX_W +: PIX_W] !== 8'((80+3)*5+1)) begin errors++; $display("FAIL simul_col3_row1: got %h want %h", rd_column[PIX_W +: PIX_W], 8'((80+3)*5+1)); end
    step();
  endtask

  task automatic test_reset_mid();
    in_valid = 1;
    for (int i = 0; i < 400; i++) begin in_data = 8'(i + 9); step(); end
    in_valid = 0;
    read_col(7);
    vectors++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_rd_valid: got %b want 1", rd_valid); end
    rst = 1'b1; #2;
    vectors++; if (win_valid !== 1'b0)   begin errors++; $display("FAIL rmid_win_valid: got %b want 0", win_valid); end
    vectors++; if (win_bank !== 1'b0)    begin errors++; $display("FAIL rmid_win_bank: got %b want 0", win_bank); end
    vectors++; if (rd_valid !== 1'b0)    begin errors++; $display("FAIL rmid_rd_valid: got %b want 0", rd_valid); end
    vectors++; if (rd_column !== '0)     begin errors++; $display("FAIL rmid_rd_column: got %h want 0", rd_column); end
    vectors++; if (release_err !== 1'b0) begin errors++; $display("FAIL rmid_release_err: got %b want 0", release_err); end
    do_reset();
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
    in_valid = 1;
    for (int i = 0; i < ROWS*COLS; i++) begin in_data = 8'((m_row*COLS + m_col)*7); step(); end
    in_valid = 0;
    vectors++; if (win_valid !== 1'b1) begin errors++; $display("FAIL rmid_fill_valid: got %b want 1", win_valid); end
    vectors++; if (win_bank !== 1'b0)  begin errors++; $display("FAIL rmid_fill_bank: got %b want 0", win_bank); end
    read_col(0); read_col(40); read_col(79);
    vectors++; if (rd_column[15*PIX_W +: PIX_W] !== 8'((15*80+79)*7)) begin errors++; $display("FAIL rmid_col79_row15: got %h want %h", rd_column[15*PIX_W +: PIX_W], 8'((15*80+79)*7)); end
    step(); step();
  endtask

  initial begin
    #1;
    test_reset();
    test_release_err();
    test_fill();
    test_backpressure();
    test_abort();
    test_simul();
    test_reset_mid();
    vectors++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ncc_window_loader.md
Name: ncc_window_loader

Overview:
- Upstream stage of the NCC correlator. Takes the PCI byte stream of search-window pixels and stores it in row-major order into ROWS row memories, one per window row.
- Double-buffered (ping-pong): one bank fills while the correlator reads the other.
- The correlator reads a full column (one pixel from every row) per access, matching the one-memory-per-row window organisation.

Parameters:
- ROWS, 16, window rows; one row memory per row per bank.
- COLS, 80, pixels per row.
- PIX_W, 8, bits per pixel.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  pixel byte present on in_data.
- in_data  in  PIX_W  pixel, row-major order (row 0 col 0 first).
- in_ready  out  1  loader accepts a pixel this cycle.
- frame_abort  in  1  discard the partially filled write bank.
- win_valid  out  1  a full bank is available to the consumer.
- win_bank  out  1  index of the bank being read (the oldest full bank).
- rd_col  in  $clog2(COLS)  column to read from the read bank.
- rd_en  in  1  read strobe.
- rd_column  out  ROWS*PIX_W  column pixels; row r occupies bits [r*PIX_W +: PIX_W].
- rd_valid  out  1  rd_column valid; asserts one cycle after rd_en.
- win_release  in  1  consumer is done with the read bank.
- release_err  out  1  sticky; set by win_release while win_valid=0.

Behaviour:
- Reset values:
  - Both bank-full flags = 0; wr_bank = 0; rd_bank = 0.
  - Column and row write counters = 0.
  - win_valid = 0, win_bank = 0, rd_column = 0, rd_valid = 0, release_err = 0.
  - in_ready = 1 in the first cycle after reset deassertion.
- Write side:
  - in_ready = !full[wr_bank] && !frame_abort (combinational).
  - A transfer occurs when in_valid && in_ready.
  - Each transfer writes in_data to bank wr_bank, row memory wr_row, address wr_col, then increments wr_col.
  - When wr_col == COLS-1, wr_col wraps to 0 and wr_row increments.
  - On the transfer at wr_row == ROWS-1 and wr_col == COLS-1:
    - full[wr_bank] <= 1;
    - wr_bank toggles;
    - both counters return to 0.
- Backpressure:
  - When both banks are full, in_ready = 0 and in_data is ignored.
  - Writing resumes the cycle after a release frees a bank.
- frame_abort: the write counters clear next cycle. Full banks, the read side and wr_bank are unaffected.
- Read side:
  - win_valid = full[rd_bank]; win_bank = rd_bank.
  - rd_en registers rd_column from bank rd_bank at rd_col, with 1-cycle latency; rd_valid pulses with it.
  - rd_en while win_valid = 0 still produces rd_valid; the data is don't-care.
  - rd_col >= COLS: rd_column is don't-care, with no state corruption.
  - rd_column holds its last value when rd_en = 0.
- Release:
  - win_release with win_valid = 1 clears full[rd_bank] and toggles rd_bank.
  - win_release with win_valid = 0 is ignored and sets release_err; release_err is cleared only by rst.
- Simultaneous events:
  - Final write of a bank and release in the same cycle: both take effect. The freed bank becomes writable next cycle. If the newly completed bank is the next rd_bank, win_valid stays 1.
  - frame_abort together with a valid transfer: the abort wins; the pixel is not written and in_ready = 0.
- Full-flag state machine per bank: EMPTY -(last pixel written)-> FULL -(release while it is rd_bank)-> EMPTY.
- Bank ordering: the banks are consumed strictly in fill order (FIFO of depth 2).
- Memories: inferred as 2*ROWS simple dual-port RAMs, each COLS deep. Contents are not cleared by reset.
- Reset mid-frame: all flags and counters return to reset values. Stale RAM contents are never marked valid.

Test Plan:
- Fill bank 0 with pixel value (r*COLS+c)&8'hFF, in_valid held high for 1280 cycles:
  - win_valid rises the cycle after the 1280th transfer, with win_bank = 0;
  - rd_col = 5 returns row r byte = (r*80+5)&8'hFF for all 16 rows, rd_valid one cycle after rd_en.
- Stream 2560 pixels with no release:
  - in_ready drops after the 2560th transfer;
  - a release then raises in_ready next cycle;
  - win_bank = 1 and column 0 shows the second-frame data.
- Send 700 pixels, pulse frame_abort, then send a full frame of 8'hAA:
  - bank 0 becomes full;
  - every column reads all bytes 8'hAA, with no shifted data.
- Release with win_valid = 0 right after reset:
  - release_err = 1 and stays 1;
  - the full flags are unchanged;
  - a subsequent fill still yields win_valid.
- Bank 1 completes in the same cycle as bank 0 is released:
  - win_valid stays 1, win_bank becomes 1;
  - in_ready = 1 next cycle.
- Assert rst after 400 pixels:
  - all outputs return to reset values;
  - a following full frame reads back correctly from bank 0.
